// File: rtl/frame_scanout_if.sv
// -----------------------------------------------------------------------------
// frame_scanout_if
// Bundles the write port, the sweep controls and the scan output stream of
// the frame store into one interface.
//   master modport : the side that issues writes and sweep pulses and consumes
//                    beats (packet decoder + glyph driver, or a testbench)
//   slave modport  : the frame store itself
// Signals:
//   wr_en/wr_col/wr_row/wr_char  write strobe and payload
//   wr_err                       pulse: a write was dropped
//   frame_start/col_tick         sweep restart / scan-one-column pulses
//   out_valid/out_ready          beat handshake
//   out_char/out_col/out_row     beat payload
//   out_last                     beat is the last row of its column
//   busy/overrun                 status: not idle / col_tick dropped
// -----------------------------------------------------------------------------
interface frame_scanout_if;
   logic       wr_en;
   logic [7:0] wr_col;
   logic [7:0] wr_row;
   logic [7:0] wr_char;
   logic       wr_err;
   logic       frame_start;
   logic       col_tick;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_char;
   logic [7:0] out_col;
   logic [7:0] out_row;
   logic       out_last;
   logic       busy;
   logic       overrun;

   modport master (
      output wr_en, wr_col, wr_row, wr_char, frame_start, col_tick, out_ready,
      input  wr_err, out_valid, out_char, out_col, out_row, out_last, busy, overrun
   );

   modport slave (
      input  wr_en, wr_col, wr_row, wr_char, frame_start, col_tick, out_ready,
      output wr_err, out_valid, out_char, out_col, out_row, out_last, busy, overrun
   );
endinterface

// File: rtl/frame_scanout.sv
// -----------------------------------------------------------------------------
// frame_scanout
// Character frame store and column scanner for the mirror display. Holds a
// COLS x ROWS character buffer written by the packet decoder and, on every
// column tick, streams one column (row 0 first) to the glyph/LED driver.
// After reset the whole buffer is cleared to BLANK before anything else runs.
// Ports:
//   master_clk  single clock, all logic on posedge
//   rst         synchronous active-high reset
//   bus         frame_scanout_if.slave (write port, sweep pulses, beat stream)
// -----------------------------------------------------------------------------
module frame_scanout #(
   parameter int         COLS  = 40,
   parameter int         ROWS  = 15,
   parameter logic [7:0] BLANK = 8'h20
) (
   input  logic            master_clk,
   input  logic            rst,
   frame_scanout_if.slave  bus
);

   localparam int DEPTH = COLS * ROWS;
   localparam int AW    = $clog2(DEPTH);

   typedef enum logic [1:0] {CLEAR, IDLE, FETCH, EMIT} state_t;

   state_t        state_q, state_d;
   logic [7:0]    curCol_q, curCol_d;
   logic [7:0]    curRow_q, curRow_d;
   logic          restartPend_q, restartPend_d;
   logic [AW-1:0] clrAddr_q, clrAddr_d;
   logic [7:0]    rdData_q;
   logic          wrErr_q;
   logic          overrun_q;

   logic [7:0]    mem [DEPTH];

   logic          wrInRange;
   logic          memWe;
   logic [AW-1:0] memWAddr;
   logic [7:0]    memWData;
   logic [AW-1:0] wrAddr;
   logic [AW-1:0] rdAddr;
   logic          accept;
   logic          scanning;

   assign wrInRange = (int'(bus.wr_col) < COLS) && (int'(bus.wr_row) < ROWS);
   assign wrAddr    = AW'(int'(bus.wr_col) * ROWS + int'(bus.wr_row));
   assign rdAddr    = AW'(int'(curCol_q) * ROWS + int'(curRow_q));
   assign accept    = (state_q == EMIT) && bus.out_ready;
   assign scanning  = (state_q == FETCH) || (state_q == EMIT);

   // The clear sweep owns the single write port while it runs; user writes
   // are only let through once the buffer is initialised.
   always_comb begin
      memWe    = 1'b0;
      memWAddr = clrAddr_q;
      memWData = BLANK;
      if (state_q == CLEAR) begin
         memWe = 1'b1;
      end else if (bus.wr_en && wrInRange) begin
         memWe    = 1'b1;
         memWAddr = wrAddr;
         memWData = bus.wr_char;
      end
   end

   // Buffer storage. Nonblocking write means a same-cycle read of the same
   // cell sees the old character.
   always_ff @(posedge master_clk) begin
      if (memWe) begin
         mem[memWAddr] <= memWData;
      end
   end

   // Registered read, captured only in FETCH so the character presented in
   // EMIT stays put however long the consumer stalls.
   always_ff @(posedge master_clk) begin
      if (rst) begin
         rdData_q <= '0;
      end else if (state_q == FETCH) begin
         rdData_q <= mem[rdAddr];
      end
   end

   // Next-state logic: clear sweep, then idle / fetch / emit per row.
   // A frame_start that lands while a column is in flight is remembered and
   // applied when that column completes.
   always_comb begin
      state_d       = state_q;
      curCol_d      = curCol_q;
      curRow_d      = curRow_q;
      restartPend_d = restartPend_q;
      clrAddr_d     = clrAddr_q;
      case (state_q)
         CLEAR: begin
            clrAddr_d = clrAddr_q + 1'b1;
            if (clrAddr_q == AW'(DEPTH - 1)) begin
               clrAddr_d = '0;
               curCol_d  = '0;
               curRow_d  = '0;
               state_d   = IDLE;
            end
         end
         IDLE: begin
            if (bus.frame_start) begin
               curCol_d = '0;
               curRow_d = '0;
               state_d  = FETCH;
            end else if (bus.col_tick) begin
               curRow_d = '0;
               state_d  = FETCH;
            end
         end
         FETCH: begin
            if (bus.frame_start) begin
               restartPend_d = 1'b1;
            end
            state_d = EMIT;
         end
         EMIT: begin
            if (bus.frame_start) begin
               restartPend_d = 1'b1;
            end
            if (accept) begin
               if (curRow_q == 8'(ROWS - 1)) begin
                  state_d       = IDLE;
                  restartPend_d = 1'b0;
                  if (restartPend_q || bus.frame_start || curCol_q == 8'(COLS - 1)) begin
                     curCol_d = '0;
                  end else begin
                     curCol_d = curCol_q + 8'd1;
                  end
               end else begin
                  curRow_d = curRow_q + 8'd1;
                  state_d  = FETCH;
               end
            end
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   // State registers and the two one-cycle status pulses.
   always_ff @(posedge master_clk) begin
      if (rst) begin
         state_q       <= CLEAR;
         curCol_q      <= '0;
         curRow_q      <= '0;
         restartPend_q <= 1'b0;
         clrAddr_q     <= '0;
         wrErr_q       <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         curCol_q      <= curCol_d;
         curRow_q      <= curRow_d;
         restartPend_q <= restartPend_d;
         clrAddr_q     <= clrAddr_d;
         wrErr_q       <= bus.wr_en && ((state_q == CLEAR) || !wrInRange);
         overrun_q     <= bus.col_tick && scanning;
      end
   end

   assign bus.out_valid = (state_q == EMIT);
   assign bus.out_char  = rdData_q;
   assign bus.out_col   = curCol_q;
   assign bus.out_row   = curRow_q;
   assign bus.out_last  = (curRow_q == 8'(ROWS - 1));
   assign bus.busy      = (state_q != IDLE);
   assign bus.wr_err    = wrErr_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_frame_scanout.sv
// -----------------------------------------------------------------------------
// tb_frame_scanout
// Self-checking bench for frame_scanout. The reference model is a plain 2-D
// character array plus the sweep column; each scan request pushes the whole
// expected column into a queue, and an independent monitor pops and compares
// each beat as the DUT hands it over.
// -----------------------------------------------------------------------------
module tb_frame_scanout;

   localparam int         COLS  = 40;
   localparam int         ROWS  = 15;
   localparam int         DEPTH = COLS * ROWS;
   localparam logic [7:0] BLANK = 8'h20;

   typedef struct {
      logic [7:0] ch;
      logic [7:0] col;
      logic [7:0] row;
      logic       last;
   } beat_t;

   logic clk;
   logic rst;

   frame_scanout_if bus();

   frame_scanout #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
      .master_clk (clk),
      .rst        (rst),
      .bus        (bus)
   );

   int         checks;
   int         errors;
   logic [7:0] model [COLS][ROWS];
   int         modelCol;
   int         scanCol;
   bit         restartPend;
   beat_t      expQ[$];
   int         wrErrExp;
   int         wrErrSeen;
   int         overrunExp;
   int         overrunSeen;
   bit         randomReady;
   bit         holdReady;
   bit         spacingCheck;
   int         cyc;
   int         lastAcceptCyc;
   beat_t      held;
   beat_t      popped;
   bit         stalled;

   // Free-running clock and cycle counter used for beat spacing.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Every comparison funnels through here so the counts stay honest.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Consumer side: ready is either held at a level or randomised each cycle.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         bus.out_ready = randomReady ? 1'($urandom_range(0, 1)) : holdReady;
      end
   end

   // Monitor: counts status pulses, checks stall stability, and scores beats.
   initial begin
      stalled       = 1'b0;
      lastAcceptCyc = 0;
      forever begin
         @(negedge clk);
         if (bus.wr_err)  wrErrSeen++;
         if (bus.overrun) overrunSeen++;
         if (bus.out_valid) begin
            if (stalled) begin
               checkOutput("stableChar", bus.out_char, held.ch);
               checkOutput("stableCol",  bus.out_col,  held.col);
               checkOutput("stableRow",  bus.out_row,  held.row);
               checkOutput("stableLast", bus.out_last, held.last);
            end
            if (bus.out_ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpectedBeat", expQ.size(), 1);
               end else begin
                  popped = expQ.pop_front();
                  checkOutput("beatChar", bus.out_char, popped.ch);
                  checkOutput("beatCol",  bus.out_col,  popped.col);
                  checkOutput("beatRow",  bus.out_row,  popped.row);
                  checkOutput("beatLast", bus.out_last, popped.last);
                  if (spacingCheck && popped.row != 8'd0) begin
                     checkOutput("beatSpacing", cyc - lastAcceptCyc, 2);
                  end
               end
               lastAcceptCyc = cyc;
               stalled       = 1'b0;
            end else begin
               held.ch   = bus.out_char;
               held.col  = bus.out_col;
               held.row  = bus.out_row;
               held.last = bus.out_last;
               stalled   = 1'b1;
            end
         end else begin
            stalled = 1'b0;
         end
      end
   end

   // Reset the DUT, check reset values, poke it during the clear and measure
   // how long the clear keeps it busy.
   task automatic resetDut();
      int busyCycles;
      @(posedge clk);
      #1 rst = 1'b1;
      expQ.delete();
      @(posedge clk);
      #1;
      checkOutput("rstValid", bus.out_valid, 0);
      checkOutput("rstChar",  bus.out_char,  0);
      checkOutput("rstCol",   bus.out_col,   0);
      checkOutput("rstRow",   bus.out_row,   0);
      checkOutput("rstLast",  bus.out_last,  0);
      checkOutput("rstBusy",  bus.busy,      1);
      @(posedge clk);
      #1;
      checkOutput("rstWrErr",   bus.wr_err,  0);
      checkOutput("rstOverrun", bus.overrun, 0);
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            model[c][r] = BLANK;
      modelCol    = 0;
      restartPend = 1'b0;
      rst             = 1'b0;
      bus.wr_en       = 1'b1;
      bus.wr_col      = 8'd1;
      bus.wr_row      = 8'd1;
      bus.wr_char     = 8'h5A;
      bus.col_tick    = 1'b1;
      bus.frame_start = 1'b1;
      wrErrExp++;
      busyCycles = 0;
      @(negedge clk);
      if (bus.busy) busyCycles++;
      @(posedge clk);
      #1;
      bus.wr_en       = 1'b0;
      bus.col_tick    = 1'b0;
      bus.frame_start = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
         busyCycles++;
      end
      checkOutput("clearBusyCycles", busyCycles, DEPTH);
   endtask

   task automatic applyWrite(input int col, input int row, input logic [7:0] ch);
      @(posedge clk);
      #1;
      bus.wr_en   = 1'b1;
      bus.wr_col  = 8'(col);
      bus.wr_row  = 8'(row);
      bus.wr_char = ch;
      if (col < COLS && row < ROWS) model[col][row] = ch;
      else wrErrExp++;
      @(posedge clk);
      #1 bus.wr_en = 1'b0;
   endtask

   // Launch one column scan from IDLE and check the two-cycle latency.
   task automatic applyStimulus(input bit isFrame);
      beat_t b;
      scanCol = isFrame ? 0 : modelCol;
      for (int r = 0; r < ROWS; r++) begin
         b.ch   = model[scanCol][r];
         b.col  = 8'(scanCol);
         b.row  = 8'(r);
         b.last = (r == ROWS - 1);
         expQ.push_back(b);
      end
      @(posedge clk);
      #1;
      if (isFrame) bus.frame_start = 1'b1;
      else         bus.col_tick    = 1'b1;
      @(posedge clk);
      #1;
      bus.frame_start = 1'b0;
      bus.col_tick    = 1'b0;
      checkOutput("latencyCycle1", bus.out_valid, 0);
      @(posedge clk);
      #1;
      checkOutput("latencyCycle2", bus.out_valid, 1);
   endtask

   // Wait for the column to drain, then advance the model's sweep column.
   task automatic finishColumn();
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
      end
      checkOutput("columnDrained", bus.busy, 0);
      checkOutput("queueEmpty", expQ.size(), 0);
      modelCol    = (restartPend || scanCol == COLS - 1) ? 0 : scanCol + 1;
      restartPend = 1'b0;
   endtask

   task automatic waitValid();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.out_valid) break;
      end
      checkOutput("validSeen", bus.out_valid, 1);
   endtask

   task automatic pulseMidColumn(input bit isFrame);
      @(posedge clk);
      #1;
      if (isFrame) bus.frame_start = 1'b1;
      else         bus.col_tick    = 1'b1;
      @(posedge clk);
      #1;
      bus.frame_start = 1'b0;
      bus.col_tick    = 1'b0;
   endtask

   // Watchdog so a stuck DUT still ends the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks          = 0;
      errors          = 0;
      wrErrExp        = 0;
      wrErrSeen       = 0;
      overrunExp      = 0;
      overrunSeen     = 0;
      randomReady     = 1'b0;
      holdReady       = 1'b1;
      spacingCheck    = 1'b1;
      rst             = 1'b1;
      bus.wr_en       = 1'b0;
      bus.wr_col      = 8'd0;
      bus.wr_row      = 8'd0;
      bus.wr_char     = 8'd0;
      bus.frame_start = 1'b0;
      bus.col_tick    = 1'b0;

      $display("[TB] reset and clear");
      resetDut();
      applyStimulus(1'b0);
      finishColumn();

      $display("[TB] single write then sweep to column 3");
      applyWrite(3, 7, 8'h41);
      applyStimulus(1'b1);
      finishColumn();
      repeat (3) begin
         applyStimulus(1'b0);
         finishColumn();
      end

      $display("[TB] out-of-range writes");
      applyWrite(40, 0, 8'h55);
      applyWrite(0, 15, 8'h55);
      @(negedge clk);
      #1;
      checkOutput("wrErrCount", wrErrSeen, wrErrExp);

      $display("[TB] random writes and full sweep with random ready");
      repeat (20) applyWrite($urandom_range(0, 44), $urandom_range(0, 17), 8'($urandom_range(0, 255)));
      randomReady  = 1'b1;
      spacingCheck = 1'b0;
      applyStimulus(1'b1);
      finishColumn();
      repeat (COLS) begin
         applyStimulus(1'b0);
         finishColumn();
      end
      randomReady = 1'b0;
      holdReady   = 1'b1;
      repeat (2) @(posedge clk);
      spacingCheck = 1'b1;

      $display("[TB] mid-column col_tick and frame_start");
      applyStimulus(1'b0);
      waitValid();
      pulseMidColumn(1'b0);
      overrunExp++;
      finishColumn();
      applyStimulus(1'b0);
      waitValid();
      pulseMidColumn(1'b1);
      restartPend = 1'b1;
      finishColumn();
      applyStimulus(1'b0);
      finishColumn();
      checkOutput("overrunCount", overrunSeen, overrunExp);

      $display("[TB] stall in EMIT then reset mid-column");
      spacingCheck = 1'b0;
      holdReady    = 1'b0;
      applyStimulus(1'b0);
      waitValid();
      repeat (10) @(negedge clk);
      resetDut();
      holdReady = 1'b1;
      repeat (2) @(posedge clk);
      spacingCheck = 1'b1;
      applyStimulus(1'b0);
      finishColumn();
      applyStimulus(1'b0);
      finishColumn();
      applyStimulus(1'b0);
      finishColumn();
      applyStimulus(1'b0);
      finishColumn();

      @(negedge clk);
      #1;
      checkOutput("finalWrErr",   wrErrSeen,   wrErrExp);
      checkOutput("finalOverrun", overrunSeen, overrunExp);
      checkOutput("finalQueue",   expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
